// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor: one CHUNK-wide CLA per stage,
// registered chunk carry between stages, skew/de-skew chains and a global valid/ready stall.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  // Whole pipe advances together; a held result freezes every stage.
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  assign b_cond = i_sub ? ~i_add2 : i_add2;
  assign c0     = i_cin ^ i_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * CW;
    localparam int unsigned REM = WIDTH - LO;

    logic [REM-1:0]     a_in;
    logic [REM-1:0]     b_in;
    logic               c_in;
    logic               v_in;
    logic [CW:0]        cy;
    logic [CW-1:0]      s_c;
    logic [LO+CW-1:0]   s_nxt;
    logic [LO+CW-1:0]   s_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_first
      assign a_in  = i_add1;
      assign b_in  = b_cond;
      assign c_in  = c0;
      assign v_in  = i_valid;
      assign s_nxt = s_c;
    end else begin : g_next
      assign a_in  = g_stage[k-1].g_skew.a_q;
      assign b_in  = g_stage[k-1].g_skew.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_nxt = {s_c, g_stage[k-1].s_q};
    end

    // Chunk CLA on the lowest CW bits still in flight.
    always_comb begin
      logic [CW:0] c;
      c   = '0;
      s_c = '0;
      c[0] = c_in;
      for (int j = 0; j < int'(CW); j++) begin
        c[j+1] = (a_in[j] & b_in[j]) | ((a_in[j] | b_in[j]) & c[j]);
        s_c[j] = a_in[j] ^ b_in[j] ^ c[j];
      end
      cy = c;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_nxt;
        c_q <= cy[CW];
        v_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-CW-1:0] a_q;
      logic [REM-CW-1:0] b_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:CW];
          b_q <= b_in[REM-1:CW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= cy[CW-1] ^ cy[CW];
        end
      end
    end
  end

  assign o_result   = g_stage[STAGES-1].s_q;
  assign o_carry    = g_stage[STAGES-1].c_q;
  assign o_valid    = g_stage[STAGES-1].v_q;
  assign o_overflow = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed vector table, back-pressure, mid-flight reset
// and randomized traffic checked by a queue scoreboard fed from an arithmetic model.
module tb_pipelined_cla_addsub;

  localparam int unsigned W = 64;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_add1;
  logic [W-1:0] i_add2;
  logic         i_cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_carry;
  logic         o_overflow;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_add1     (i_add1),
    .i_add2     (i_add2),
    .i_cin      (i_cin),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  logic stalled = 1'b0;
  logic [W-1:0] held;
  bit   rnd_done;

  // Reference: plain (W+1)-bit arithmetic and the two's-complement sign rule.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic [W:0]   s;
    res_t         e;
    bp  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bp} + (W+1)'(cin ^ sub);
    e.r = s[W-1:0];
    e.c = s[W];
    e.o = (a[W-1] == bp[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard, sampled on the falling edge so every value is settled.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", W'(o_valid), W'(1));
        chk("stall_hold", o_result, held);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h expected no result", o_result);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", o_result, e.r);
          chk("sb_carry", W'(o_carry), W'(e.c));
          chk("sb_overflow", W'(o_overflow), W'(e.o));
        end
        n_out++;
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_add1, i_add2, i_cin, i_sub));
      stalled = o_valid && !i_ready;
      held    = o_result;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int n;
    i_add1 = a; i_add2 = b; i_cin = cin; i_sub = sub; i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got o_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Single op into an empty pipe: exact latency plus table values.
  task automatic check_vec(input vec_t v, input int idx);
    int n;
    i_ready = 1'b1;
    i_add1 = v.a; i_add2 = v.b; i_cin = v.cin; i_sub = v.sub; i_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_ready", idx), W'(o_ready), W'(1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), W'(n), W'(S));
    chk($sformatf("vec%0d_result", idx), o_result, v.r);
    chk($sformatf("vec%0d_carry", idx), W'(o_carry), W'(v.c));
    chk($sformatf("vec%0d_overflow", idx), W'(o_overflow), W'(v.o));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   n0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'd10, 64'd4, 1'b1, 1'b1, 64'd5, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[8] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_add1 = '0; i_add2 = '0; i_cin = 1'b0; i_sub = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_result", o_result, '0);
    chk("rst_carry", W'(o_carry), W'(0));
    chk("rst_overflow", W'(o_overflow), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_valid", W'(o_valid), W'(0));
    chk("idle_ready", W'(o_ready), W'(1));

    for (int i = 0; i < 9; i++) check_vec(vecs[i], i);

    // Back-pressure: 8 back-to-back ops, i_ready low for 5 cycles.
    n0 = n_out;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(W'(i), W'(100 * i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", W'(n_out - n0), W'(8));

    // Reset while three ops are in flight.
    n0 = n_out;
    send(64'd11, 64'd22, 1'b0, 1'b0);
    send(64'd33, 64'd44, 1'b0, 1'b0);
    send(64'd55, 64'd66, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("flush_no_valid", W'(o_valid), W'(0));
    end
    chk("flush_count", W'(n_out - n0), W'(0));
    check_vec(vecs[0], 100);

    // Random traffic with random back-pressure.
    n0 = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(3) == 0) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
          end else begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(7))
              0: ra = '1;
              1: rb = '1;
              2: ra = {1'b0, {(W-1){1'b1}}};
              3: rb = {1'b1, {(W-1){1'b0}}};
              default: ;
            endcase
            send(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #2;
          i_ready = ($urandom_range(3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();
    tests++;
    if (n_out - n0 < 200) begin
      fails++;
      $display("FAIL random_count: got %0d results expected at least 200", n_out - n0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
